l2_state_rw_arb: RTL

- Arbitrates the L2 state array's single read port and single write port between pipe1 (request pipeline) and pipe2 (memory-ack/fill pipeline).
- Runs a post-reset clear sweep over the array before any access is granted.
- Forwards same-cycle write data into the next-cycle read result, using the masked merge (wdata & mask) | (rdata & ~mask).
- Sits between the two pipeline controllers and the state array wrapper.

---
 rtl/l2_state_rw_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/l2_state_rw_arb.sv
// l2_state_rw_arb: arbitrates the L2 state array's single read port and
// single write port between pipe1 (requests) and pipe2 (memory-ack/fill).
// After reset it clears every array entry before granting any access.
// Same-index read/write collisions are resolved by forwarding the masked
// write data into the read result returned on the following cycle.
// Optional statistics counters: define L2_STATE_ARB_STAT_EN.
module l2_state_rw_arb #(
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned DATA_WIDTH  = 66
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   p1_rd_req,
  input  logic [INDEX_WIDTH-1:0] p1_rd_index,
  output logic                   p1_rd_gnt,
  output logic                   p1_rd_vld,
  output logic [DATA_WIDTH-1:0]  p1_rd_data,
  input  logic                   p2_rd_req,
  input  logic [INDEX_WIDTH-1:0] p2_rd_index,
  output logic                   p2_rd_gnt,
  output logic                   p2_rd_vld,
  output logic [DATA_WIDTH-1:0]  p2_rd_data,
  input  logic                   p1_wr_en,
  input  logic [INDEX_WIDTH-1:0] p1_wr_index,
  input  logic [DATA_WIDTH-1:0]  p1_wr_data,
  input  logic [DATA_WIDTH-1:0]  p1_wr_mask,
  output logic                   p1_wr_rdy,
  input  logic                   p2_wr_en,
  input  logic [INDEX_WIDTH-1:0] p2_wr_index,
  input  logic [DATA_WIDTH-1:0]  p2_wr_data,
  input  logic [DATA_WIDTH-1:0]  p2_wr_mask,
  output logic                   p2_wr_rdy,
  output logic                   arr_rd_en,
  output logic [INDEX_WIDTH-1:0] arr_rd_index,
  input  logic [DATA_WIDTH-1:0]  arr_rd_data,
  output logic                   arr_wr_en,
  output logic [INDEX_WIDTH-1:0] arr_wr_index,
  output logic [DATA_WIDTH-1:0]  arr_wr_data,
  output logic [DATA_WIDTH-1:0]  arr_wr_mask,
  output logic                   init_done
`ifdef L2_STATE_ARB_STAT_EN
  ,
  output logic [15:0]            rd_conflict_cnt,
  output logic [15:0]            wr_conflict_cnt
`endif
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
  logic                   rr_p2_last_q, rr_p2_last_d;
  logic                   bypass_next_q, bypass_next_d;
  logic                   p1_rd_vld_q, p1_rd_vld_d;
  logic                   p2_rd_vld_q, p2_rd_vld_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]  wr_mask_q, wr_mask_d;
  logic                   init_done_q, init_done_d;
  logic                   active;
  logic                   sweeping;
  logic [DATA_WIDTH-1:0]  rd_merged;

  // Arbitration, array port muxing and next-state computation.
  // Every grant/enable is qualified with ~rst because reset is synchronous
  // and the registered state is only cleared at the next edge.
  always_comb begin
    active   = (state_q == ST_RUN) && !rst;
    sweeping = (state_q == ST_INIT) && !rst;

    p1_rd_gnt = active & p1_rd_req & (~p2_rd_req | rr_p2_last_q);
    p2_rd_gnt = active & p2_rd_req & (~p1_rd_req | ~rr_p2_last_q);
    arr_rd_en    = p1_rd_gnt | p2_rd_gnt;
    arr_rd_index = p2_rd_gnt ? p2_rd_index : p1_rd_index;

    p2_wr_rdy = active & p2_wr_en;
    p1_wr_rdy = active & p1_wr_en & ~p2_wr_en;

    if (sweeping) begin
      arr_wr_en    = 1'b1;
      arr_wr_index = sweep_cnt_q;
      arr_wr_data  = '0;
      arr_wr_mask  = '1;
    end else begin
      arr_wr_en    = p1_wr_rdy | p2_wr_rdy;
      arr_wr_index = p2_wr_rdy ? p2_wr_index : p1_wr_index;
      arr_wr_data  = p2_wr_rdy ? p2_wr_data  : p1_wr_data;
      arr_wr_mask  = p2_wr_rdy ? p2_wr_mask  : p1_wr_mask;
    end

    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    if (state_q == ST_INIT) begin
      sweep_cnt_d = sweep_cnt_q + INDEX_WIDTH'(1);
      if (sweep_cnt_q == '1) state_d = ST_RUN;
    end
    init_done_d = (state_d == ST_RUN);

    rr_p2_last_d = (active && p1_rd_req && p2_rd_req) ? p2_rd_gnt : rr_p2_last_q;

    bypass_next_d = arr_rd_en & arr_wr_en & (arr_rd_index == arr_wr_index);
    wr_data_d     = bypass_next_d ? arr_wr_data : wr_data_q;
    wr_mask_d     = bypass_next_d ? arr_wr_mask : wr_mask_q;

    p1_rd_vld_d = p1_rd_gnt;
    p2_rd_vld_d = p2_rd_gnt;
  end

  // State, sweep counter, RR pointer, read-return and bypass registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      sweep_cnt_q   <= '0;
      rr_p2_last_q  <= 1'b0;
      bypass_next_q <= 1'b0;
      p1_rd_vld_q   <= 1'b0;
      p2_rd_vld_q   <= 1'b0;
      wr_data_q     <= '0;
      wr_mask_q     <= '0;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_cnt_q   <= sweep_cnt_d;
      rr_p2_last_q  <= rr_p2_last_d;
      bypass_next_q <= bypass_next_d;
      p1_rd_vld_q   <= p1_rd_vld_d;
      p2_rd_vld_q   <= p2_rd_vld_d;
      wr_data_q     <= wr_data_d;
      wr_mask_q     <= wr_mask_d;
      init_done_q   <= init_done_d;
    end
  end

  // Read return: merge forwarded write data over the array's stale value.
  always_comb begin
    rd_merged  = bypass_next_q ? ((wr_data_q & wr_mask_q) | (arr_rd_data & ~wr_mask_q))
                               : arr_rd_data;
    p1_rd_vld  = p1_rd_vld_q;
    p2_rd_vld  = p2_rd_vld_q;
    p1_rd_data = p1_rd_vld_q ? rd_merged : '0;
    p2_rd_data = p2_rd_vld_q ? rd_merged : '0;
    init_done  = init_done_q;
  end

`ifdef L2_STATE_ARB_STAT_EN
  logic [15:0] rd_conflict_cnt_q, rd_conflict_cnt_d;
  logic [15:0] wr_conflict_cnt_q, wr_conflict_cnt_d;

  // Saturating conflict counters, next-value computation.
  always_comb begin
    rd_conflict_cnt_d = rd_conflict_cnt_q;
    wr_conflict_cnt_d = wr_conflict_cnt_q;
    if (active && p1_rd_req && p2_rd_req && rd_conflict_cnt_q != 16'hFFFF)
      rd_conflict_cnt_d = rd_conflict_cnt_q + 16'd1;
    if (active && p1_wr_en && p2_wr_en && wr_conflict_cnt_q != 16'hFFFF)
      wr_conflict_cnt_d = wr_conflict_cnt_q + 16'd1;
  end

  // Conflict counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_conflict_cnt_q <= '0;
      wr_conflict_cnt_q <= '0;
    end else begin
      rd_conflict_cnt_q <= rd_conflict_cnt_d;
      wr_conflict_cnt_q <= wr_conflict_cnt_d;
    end
  end

  assign rd_conflict_cnt = rd_conflict_cnt_q;
  assign wr_conflict_cnt = wr_conflict_cnt_q;
`endif

endmodule
